// File: rtl/play_engine.sv
// play_engine: streams a length-prefixed clip from SDRAM to the audio port through a prefetch FIFO,
// with sample repeat, address stride, pause, stop and record-copy. Define PLAY_ENGINE_LOOP_EN for endless looping.
module play_engine #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_W      = 3,
    parameter int STRIDE_W   = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                play_start,
    input  logic [ADDR_W-1:0]   play_src,
    input  logic [ADDR_W-1:0]   play_dst,
    input  logic                play_record,
    input  logic [REP_W-1:0]    play_repeat,
    input  logic [STRIDE_W-1:0] play_stride,
    input  logic                play_pause,
    input  logic                play_stop,
    output logic                play_done,
    output logic                play_busy,
    output logic                sd_read,
    output logic                sd_write,
    output logic [ADDR_W-1:0]   sd_addr,
    output logic [DATA_W-1:0]   sd_writedata,
    input  logic [DATA_W-1:0]   sd_readdata,
    input  logic                sd_finished,
    output logic                aud_valid,
    output logic [DATA_W-1:0]   aud_data,
    input  logic                aud_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, RD_LEN, STREAM, WR_LEN, DONE} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   src_reg, dst_reg, end_addr_reg, wr_addr_reg, wcount_reg;
    // One extra bit so a stride step past the top of the address space still compares as beyond the end.
    logic [ADDR_W:0]     rd_addr_reg;
    logic                record_reg, stop_reg, pend_valid_reg;
    logic [REP_W-1:0]    repeat_reg, rep_cnt_reg;
    logic [STRIDE_W-1:0] stride_reg;
    logic [DATA_W-1:0]   pend_data_reg;
    logic                sd_read_reg, sd_write_reg;
    logic [ADDR_W-1:0]   sd_addr_reg;
    logic [DATA_W-1:0]   sd_wdata_reg;

    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    cnt_reg;

    logic                port_idle, fifo_empty, fifo_full, rd_in_range;
    logic                aud_valid_int, accept, pop, push, flush;
    logic [ADDR_W:0]     rd_step;

    always_comb begin
        port_idle     = !sd_read_reg && !sd_write_reg;
        fifo_empty    = (cnt_reg == '0);
        fifo_full     = (cnt_reg == FIFO_FULL_CNT);
        rd_in_range   = (rd_addr_reg <= {1'b0, end_addr_reg});
        aud_valid_int = (state_reg == STREAM) && !fifo_empty && !play_pause
                        && !pend_valid_reg && !stop_reg;
        accept        = aud_valid_int && aud_ready;
        pop           = accept && (rep_cnt_reg == repeat_reg);
        push          = (state_reg == STREAM) && sd_read_reg && sd_finished;
        // Stop completes only once the shared port is quiet.
        flush         = stop_reg && port_idle
                        && ((state_reg == STREAM) || (state_reg == RD_LEN));
        rd_step       = (ADDR_W+1)'(stride_reg) + (ADDR_W+1)'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            end_addr_reg   <= '0;
            wr_addr_reg    <= '0;
            wcount_reg     <= '0;
            rd_addr_reg    <= '0;
            record_reg     <= 1'b0;
            stop_reg       <= 1'b0;
            pend_valid_reg <= 1'b0;
            repeat_reg     <= '0;
            rep_cnt_reg    <= '0;
            stride_reg     <= '0;
            pend_data_reg  <= '0;
            sd_read_reg    <= 1'b0;
            sd_write_reg   <= 1'b0;
            sd_addr_reg    <= '0;
            sd_wdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    stop_reg <= 1'b0;
                    if (play_start) begin
                        src_reg        <= play_src;
                        dst_reg        <= play_dst;
                        record_reg     <= play_record;
                        repeat_reg     <= play_repeat;
                        stride_reg     <= play_stride;
                        wcount_reg     <= '0;
                        rep_cnt_reg    <= '0;
                        pend_valid_reg <= 1'b0;
                        sd_read_reg    <= 1'b1;
                        sd_addr_reg    <= play_src;
                        state_reg      <= RD_LEN;
                    end
                end
                RD_LEN: begin
                    if (play_stop) stop_reg <= 1'b1;
                    if (sd_read_reg && sd_finished) begin
                        sd_read_reg <= 1'b0;
                        if (!stop_reg && !play_stop) begin
                            end_addr_reg <= src_reg + sd_readdata[ADDR_W-1:0];
                            rd_addr_reg  <= {1'b0, src_reg + ADDR_W'(1)};
                            wr_addr_reg  <= dst_reg + ADDR_W'(1);
                            state_reg    <= STREAM;
                        end
                    end else if (flush) begin
                        stop_reg <= 1'b0;
                        if (record_reg) begin
                            sd_write_reg <= 1'b1;
                            sd_addr_reg  <= dst_reg;
                            sd_wdata_reg <= DATA_W'(wcount_reg);
                            state_reg    <= WR_LEN;
                        end else begin
                            state_reg <= DONE;
                        end
                    end
                end
                STREAM: begin
                    if (play_stop) stop_reg <= 1'b1;
                    if (sd_read_reg && sd_finished) begin
                        sd_read_reg <= 1'b0;
                        rd_addr_reg <= rd_addr_reg + rd_step;
                    end
                    if (sd_write_reg && sd_finished) begin
                        sd_write_reg   <= 1'b0;
                        pend_valid_reg <= 1'b0;
                        wr_addr_reg    <= wr_addr_reg + ADDR_W'(1);
                        wcount_reg     <= wcount_reg + ADDR_W'(1);
                    end
                    if (accept) rep_cnt_reg <= pop ? '0 : rep_cnt_reg + REP_W'(1);
                    if (pop && record_reg) begin
                        pend_valid_reg <= 1'b1;
                        pend_data_reg  <= fifo_mem[rd_ptr_reg];
                    end
                    if (flush) begin
                        stop_reg       <= 1'b0;
                        pend_valid_reg <= 1'b0;
                        rep_cnt_reg    <= '0;
                        if (record_reg) begin
                            sd_write_reg <= 1'b1;
                            sd_addr_reg  <= dst_reg;
                            sd_wdata_reg <= DATA_W'(wcount_reg);
                            state_reg    <= WR_LEN;
                        end else begin
                            state_reg <= DONE;
                        end
                    end else if (port_idle && !stop_reg && !play_stop) begin
                        // Pending record write wins over the next prefetch read.
                        if (pend_valid_reg) begin
                            sd_write_reg <= 1'b1;
                            sd_addr_reg  <= wr_addr_reg;
                            sd_wdata_reg <= pend_data_reg;
                        end else if (!rd_in_range && fifo_empty) begin
                            if (record_reg) begin
                                sd_write_reg <= 1'b1;
                                sd_addr_reg  <= dst_reg;
                                sd_wdata_reg <= DATA_W'(wcount_reg);
                                state_reg    <= WR_LEN;
                            end else begin
`ifdef PLAY_ENGINE_LOOP_EN
                                rd_addr_reg <= {1'b0, src_reg + ADDR_W'(1)};
`else
                                state_reg <= DONE;
`endif
                            end
                        end else if (rd_in_range && !fifo_full && !play_pause) begin
                            sd_read_reg <= 1'b1;
                            sd_addr_reg <= rd_addr_reg[ADDR_W-1:0];
                        end
                    end
                end
                WR_LEN: begin
                    stop_reg <= 1'b0;
                    if (sd_write_reg && sd_finished) begin
                        sd_write_reg <= 1'b0;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    stop_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge i_clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) fifo_mem[gi] <= sd_readdata;
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            cnt_reg <= cnt_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign play_done    = (state_reg == DONE);
    assign play_busy    = (state_reg != IDLE);
    assign sd_read      = sd_read_reg;
    assign sd_write     = sd_write_reg;
    assign sd_addr      = sd_addr_reg;
    assign sd_writedata = sd_wdata_reg;
    assign aud_valid    = aud_valid_int;
    assign aud_data     = fifo_mem[rd_ptr_reg];

endmodule

// File: tb/tb_play_engine.sv
// Scoreboard bench for play_engine: a small SDRAM model plus queues of expected reads, writes and samples.
module tb_play_engine;
    localparam int AW = 23, DW = 32, DEP = 4, RW = 3, SW = 3, LAT = 2;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          play_start, play_record, play_pause, play_stop;
    logic [AW-1:0] play_src, play_dst;
    logic [RW-1:0] play_repeat;
    logic [SW-1:0] play_stride;
    logic          play_done, play_busy, sd_read, sd_write, sd_finished;
    logic [AW-1:0] sd_addr;
    logic [DW-1:0] sd_writedata, sd_readdata, aud_data;
    logic          aud_valid, aud_ready;

    always #5 clk = ~clk;

    play_engine #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEP), .REP_W(RW), .STRIDE_W(SW)) dut (
        .i_clk(clk), .i_rst(i_rst), .play_start(play_start), .play_src(play_src),
        .play_dst(play_dst), .play_record(play_record), .play_repeat(play_repeat),
        .play_stride(play_stride), .play_pause(play_pause), .play_stop(play_stop),
        .play_done(play_done), .play_busy(play_busy), .sd_read(sd_read), .sd_write(sd_write),
        .sd_addr(sd_addr), .sd_writedata(sd_writedata), .sd_readdata(sd_readdata),
        .sd_finished(sd_finished), .aud_valid(aud_valid), .aud_data(aud_data),
        .aud_ready(aud_ready)
    );

    logic [DW-1:0]    mem [0:1023];
    logic [DW-1:0]    exp_aud [$];
    logic [AW-1:0]    exp_rd [$];
    logic [AW+DW-1:0] exp_wr [$];

    int n_checks = 0, n_fail = 0;
    int acc_cnt = 0, wfin_cnt = 0, done_cnt = 0, valid_cnt = 0;
    int pause_valid = 0, pause_viol = 0, pause_neg = 0, lat = 0;
    bit in_pause = 0, prev_rd = 0;
    logic [DW-1:0]    e_aud;
    logic [AW-1:0]    e_rd;
    logic [AW+DW-1:0] e_wr;

    function automatic logic [DW-1:0] smp(input int a);
        return 32'hA500_0000 + 32'(a);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // SDRAM model: completes each request LAT cycles after it is first seen.
    always begin
        @(posedge clk);
        #1;
        if (sd_finished) begin
            sd_finished = 1'b0;
            lat = 0;
        end else if (sd_read || sd_write) begin
            lat++;
            if (lat >= LAT) begin
                sd_finished = 1'b1;
                if (sd_read) sd_readdata = mem[sd_addr[9:0]];
                else         mem[sd_addr[9:0]] = sd_writedata;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a transaction.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (aud_valid && aud_ready) begin
                acc_cnt++;
                $display("aud sample %h", aud_data);
                if (exp_aud.size() == 0) check("aud_unexpected", 64'(aud_data), 64'hX);
                else begin
                    e_aud = exp_aud.pop_front();
                    check("aud_data", 64'(aud_data), 64'(e_aud));
                end
            end
            if (sd_finished && sd_read) begin
                $display("sd read  %h -> %h", sd_addr, sd_readdata);
                if (exp_rd.size() == 0) check("rd_unexpected", 64'(sd_addr), 64'hX);
                else begin
                    e_rd = exp_rd.pop_front();
                    check("rd_addr", 64'(sd_addr), 64'(e_rd));
                end
            end
            if (sd_finished && sd_write) begin
                wfin_cnt++;
                $display("sd write %h <- %h", sd_addr, sd_writedata);
                if (exp_wr.size() == 0) check("wr_unexpected", 64'({sd_addr, sd_writedata}), 64'hX);
                else begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr_data", 64'({sd_addr, sd_writedata}), 64'(e_wr));
                end
            end
            if (sd_read && sd_write) check("rd_wr_exclusive", 64'(1), 64'(0));
            if (play_done) done_cnt++;
            if (aud_valid) valid_cnt++;
            if (in_pause) begin
                if (aud_valid) pause_valid++;
                if (sd_read && !prev_rd && pause_neg >= 1) pause_viol++;
                pause_neg++;
            end
            prev_rd = sd_read;
        end
    end

    task automatic load(input int src, input int n);
        mem[src] = 32'(n);
        for (int i = 1; i <= n; i++) mem[src + i] = smp(src + i);
    endtask

    task automatic start(input int src, input int dst, input bit rec, input int rep, input int str);
        done_cnt = 0; acc_cnt = 0; wfin_cnt = 0; valid_cnt = 0;
        @(posedge clk); #1;
        play_src = AW'(src); play_dst = AW'(dst); play_record = rec;
        play_repeat = RW'(rep); play_stride = SW'(str); play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        play_repeat = '0; play_stride = '0;
    endtask

    task automatic wait_acc(input int target);
        int k = 0;
        while (acc_cnt < target && k < 2000) begin @(posedge clk); #1; k++; end
        check("accept_timeout", 64'(acc_cnt >= target), 64'(1));
    endtask

    task automatic wait_wfin(input int target);
        int k = 0;
        while (wfin_cnt < target && k < 2000) begin @(posedge clk); #1; k++; end
        check("write_timeout", 64'(wfin_cnt >= target), 64'(1));
    endtask

    task automatic wait_done(input string name, input bit chk_rd);
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin @(posedge clk); #1; k++; end
        check({name, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        check({name, "_done_once"}, 64'(done_cnt), 64'(1));
        check({name, "_busy_low"}, 64'(play_busy), 64'(0));
        check({name, "_aud_left"}, 64'(exp_aud.size()), 64'(0));
        check({name, "_wr_left"}, 64'(exp_wr.size()), 64'(0));
        if (chk_rd) check({name, "_rd_left"}, 64'(exp_rd.size()), 64'(0));
        exp_rd.delete();
    endtask

    initial begin
        i_rst = 1'b1; play_start = 0; play_record = 0; play_pause = 0; play_stop = 0;
        play_src = '0; play_dst = '0; play_repeat = '0; play_stride = '0;
        sd_finished = 0; sd_readdata = '0; aud_ready = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        check("rst_busy", 64'(play_busy), 64'(0));
        check("rst_done", 64'(play_done), 64'(0));
        check("rst_aud_valid", 64'(aud_valid), 64'(0));
        check("rst_sd_req", 64'({sd_read, sd_write}), 64'(0));
        check("rst_sd_addr", 64'(sd_addr), 64'(0));

        // Plain playback of three samples
        load(12'h100, 3);
        exp_rd = '{23'h100, 23'h101, 23'h102, 23'h103};
        exp_aud = '{smp(12'h101), smp(12'h102), smp(12'h103)};
        aud_ready = 1'b1;
        start(12'h100, 0, 0, 0, 0);
        wait_done("plain", 1);

        // Each sample repeated four times
        load(12'h120, 2);
        exp_rd = '{23'h120, 23'h121, 23'h122};
        for (int i = 0; i < 4; i++) exp_aud.push_back(smp(12'h121));
        for (int i = 0; i < 4; i++) exp_aud.push_back(smp(12'h122));
        start(12'h120, 0, 0, 3, 0);
        wait_done("repeat", 1);
        check("repeat_accepts", 64'(acc_cnt), 64'(8));

        // Stride of three words
        load(12'h140, 7);
        exp_rd = '{23'h140, 23'h141, 23'h144, 23'h147};
        exp_aud = '{smp(12'h141), smp(12'h144), smp(12'h147)};
        start(12'h140, 0, 0, 0, 2);
        wait_done("stride", 1);

        // Record copy to 0x200
        load(12'h160, 4);
        exp_rd = '{23'h160, 23'h161, 23'h162, 23'h163, 23'h164};
        for (int i = 1; i <= 4; i++) begin
            exp_aud.push_back(smp(12'h160 + i));
            exp_wr.push_back({AW'(12'h200 + i), smp(12'h160 + i)});
        end
        exp_wr.push_back({23'h200, 32'd4});
        start(12'h160, 12'h200, 1, 0, 0);
        wait_done("record", 1);
        check("record_mem_len", 64'(mem[10'h200]), 64'(4));

        // Pause for 20 cycles after three accepts with repeat=1
        load(12'h180, 6);
        for (int i = 0; i <= 6; i++) exp_rd.push_back(AW'(12'h180 + i));
        for (int i = 1; i <= 6; i++) begin
            exp_aud.push_back(smp(12'h180 + i));
            exp_aud.push_back(smp(12'h180 + i));
        end
        start(12'h180, 0, 0, 1, 0);
        wait_acc(3);
        play_pause = 1'b1; pause_valid = 0; pause_viol = 0; pause_neg = 0; in_pause = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        play_pause = 1'b0; in_pause = 1'b0;
        check("pause_valid_cycles", 64'(pause_valid), 64'(0));
        check("pause_new_reads", 64'(pause_viol), 64'(0));
        check("pause_accepts", 64'(acc_cnt), 64'(3));
        wait_done("pause", 1);

        // Stop after two recorded samples
        load(12'h1C0, 5);
        for (int i = 0; i <= 5; i++) exp_rd.push_back(AW'(12'h1C0 + i));
        exp_aud = '{smp(12'h1C1), smp(12'h1C2)};
        exp_wr = '{{23'h221, smp(12'h1C1)}, {23'h222, smp(12'h1C2)}, {23'h220, 32'd2}};
        start(12'h1C0, 12'h220, 1, 0, 0);
        wait_acc(2);
        aud_ready = 1'b0;
        wait_wfin(2);
        play_stop = 1'b1;
        @(posedge clk); #1;
        play_stop = 1'b0;
        wait_done("stop", 0);
        check("stop_accepts", 64'(acc_cnt), 64'(2));
        aud_ready = 1'b1;

        // Empty clip
        load(12'h1E0, 0);
        exp_rd = '{23'h1E0};
        start(12'h1E0, 0, 0, 0, 0);
        wait_done("empty", 1);
        check("empty_valid_cycles", 64'(valid_cnt), 64'(0));

        // Stop while idle has no effect
        done_cnt = 0;
        @(posedge clk); #1 play_stop = 1'b1;
        @(posedge clk); #1 play_stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_stop_busy", 64'(play_busy), 64'(0));
        check("idle_stop_done", 64'(done_cnt), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
